pc_sequencer: RTL

Parametrised program-counter sequencer for the RV32I-style core; the next generation of the single-stall PC block. It generates the fetch address `IP` and the link value `PC_def`. Control-flow ops (JAL, JALR, BRANCH) stall fetch for a configurable number of bubbles before resolving. It adds true JALR targeting from `RS1_DATA`, an external fetch hold, a trap/redirect override, and misaligned-target trapping.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_target_calc.sv | 30 +++
 rtl/pc_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer shared types: opcodes, FSM states, control-op kinds.
package pc_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {
    INC,
    WAIT
  } state_e;

  typedef enum logic [1:0] {
    K_JAL,
    K_JALR,
    K_BR
  } kind_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Sequencer bus: control inputs from the core, fetch outputs back.
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic [6:0]      OP;
  logic            b_taken;
  logic [XLEN-1:0] up_amt;
  logic [XLEN-1:0] RS1_DATA;
  logic            hold;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] IP;
  logic [XLEN-1:0] PC_def;
  logic            fetch_valid;
  logic            misalign_err;

  modport master (
    output OP, b_taken, up_amt, RS1_DATA,
    output hold, redirect_valid, redirect_pc,
    input  IP, PC_def, fetch_valid, misalign_err
  );

  modport slave (
    input  OP, b_taken, up_amt, RS1_DATA,
    input  hold, redirect_valid, redirect_pc,
    output IP, PC_def, fetch_valid, misalign_err
  );
endinterface

// File: rtl/pc_target_calc.sv
// Resolved control-flow target and its alignment check.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  kind_e           kind_i,
  input  logic [XLEN-1:0] ctrl_pc_i,
  input  logic [XLEN-1:0] up_amt_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] pc_sum;

  assign jalr_sum = rs1_i + up_amt_i;
  assign pc_sum   = ctrl_pc_i + up_amt_i;

  always_comb begin
    target_o = pc_sum;
    if (kind_i == K_JALR) begin
      target_o = {jalr_sum[XLEN-1:1], 1'b0};
    end
  end

  assign misalign_o = |target_o[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch address, link value, stalled
// control-op resolution with redirect, hold and misalign trapping.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'('h100),
  parameter int              BR_BUBBLES = 1
) (
  input logic         CLK,
  input logic         RESET,
  pc_sequencer_if.slave bus
);

  if (BR_BUBBLES < 1) begin : g_bad_bubbles
    $error("BR_BUBBLES must be >= 1");
  end

  localparam int CW =
    (BR_BUBBLES > 1) ? $clog2(BR_BUBBLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(BR_BUBBLES - 1);

  state_e          state_q;
  kind_e           kind_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] ip_q;
  logic [XLEN-1:0] ctrl_pc_q;
  logic            mis_q;

  logic            is_ctrl;
  kind_e           op_kind;
  logic            taken;
  logic [XLEN-1:0] tgt;
  logic            tgt_mis;

  always_comb begin
    is_ctrl = 1'b1;
    op_kind = K_JAL;
    unique case (bus.OP)
      OP_JAL:    op_kind = K_JAL;
      OP_JALR:   op_kind = K_JALR;
      OP_BRANCH: op_kind = K_BR;
      default:   is_ctrl = 1'b0;
    endcase
  end

  pc_target_calc #(
    .XLEN(XLEN)
  ) u_tgt (
    .kind_i    (kind_q),
    .ctrl_pc_i (ctrl_pc_q),
    .up_amt_i  (bus.up_amt),
    .rs1_i     (bus.RS1_DATA),
    .target_o  (tgt),
    .misalign_o(tgt_mis)
  );

  assign taken = (kind_q != K_BR) || bus.b_taken;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ip_q      <= RESET_VEC;
      state_q   <= INC;
      cnt_q     <= '0;
      mis_q     <= 1'b0;
      kind_q    <= K_JAL;
      ctrl_pc_q <= '0;
    end else if (bus.redirect_valid) begin
      ip_q    <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      state_q <= INC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else if (bus.hold) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      unique case (state_q)
        INC: begin
          if (is_ctrl) begin
            kind_q    <= op_kind;
            ctrl_pc_q <= ip_q;
            cnt_q     <= CNT_LOAD;
            state_q   <= WAIT;
          end else begin
            ip_q <= ip_q + XLEN'(4);
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= INC;
            if (!taken) begin
              ip_q <= ctrl_pc_q + XLEN'(4);
            end else if (tgt_mis) begin
              ip_q  <= TRAP_VEC;
              mis_q <= 1'b1;
            end else begin
              ip_q <= tgt;
            end
          end
        end
      endcase
    end
  end

  assign bus.IP           = ip_q;
  assign bus.PC_def       = ip_q + XLEN'(4);
  assign bus.fetch_valid  = (state_q == INC) && !RESET;
  assign bus.misalign_err = mis_q;

endmodule
